sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Sequences every access to the shared 64Kx8 SRAM and arbitrates it between two requesters: the clock-port (Amiga) register front end and the Raspberry Pi register front end.
- It is the only block that drives RAM_A, RAM_OE_n and RAM_WE_n, and the only SRAM-side driver of the shared D bus.
- Each requester sees a simple req/ack single-byte transaction; the arbiter generates the SRAM strobe timing.

Parameters:
ACCESS_CYCLES, 3, cycles RAM_OE_n/RAM_WE_n stay low per access; legal range 1..15.
ADDR_W, 16, SRAM address width.

Ports:
CLK  input  1  system clock (~85 MHz)
RESET_n  input  1  asynchronous active-low reset
CP_REQ  input  1  clock-port request, level; held until CP_ACK
CP_WE  input  1  1 = write, 0 = read; stable while CP_REQ=1
CP_ADDR  input  ADDR_W  access address; stable while CP_REQ=1
CP_WDATA  input  8  write data; stable while CP_REQ=1
CP_ACK  output  1  one-cycle completion pulse
CP_RDATA  output  8  read data, valid from CP_ACK onward until next CP read completes
PI_REQ_M  input  1  Pi request (same rules as CP_REQ)
PI_WE_M  input  1  as CP_WE
PI_ADDR  input  ADDR_W  as CP_ADDR
PI_WDATA  input  8  as CP_WDATA
PI_ACK  output  1  as CP_ACK
PI_RDATA  output  8  as CP_RDATA
RAM_A  output  ADDR_W  SRAM address
RAM_OE_n  output  1  SRAM output enable, active low
RAM_WE_n  output  1  SRAM write enable, active low
D_OUT  output  8  data to shared bus
D_OE  output  1  1 = arbiter drives D (top level tri-states)
D_IN  input  8  shared bus read-back
BUSY  output  1  high in any state other than IDLE
GNT_PI  output  1  owner of current/last access: 0 = CP, 1 = PI

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; RAM_OE_n=1, RAM_WE_n=1, D_OE=0; CP_ACK=PI_ACK=0; RAM_A=0, D_OUT=0; CP_RDATA=PI_RDATA=0; GNT_PI=1; BUSY=0.
- Reset mid-access aborts the access: strobes release at once, no ACK is issued, and the requester must reissue.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE, at an edge with any REQ high:
  - Select the winner and set GNT_PI.
  - Latch addr/we/wdata into RAM_A/D_OUT.
  - D_OE=we.
  - Go to SETUP.
- SETUP (exactly 1 cycle): address/data settle with strobes high. Next edge: RAM_WE_n=0 (write) or RAM_OE_n=0 (read), cnt=ACCESS_CYCLES-1, go to ACCESS.
- ACCESS: decrement cnt each edge. At the edge with cnt==0:
  - Deassert the strobe.
  - Pulse the winner's ACK for 1 cycle.
  - On a read, capture D_IN into the winner's RDATA.
  - Go to RECOVER.
- RECOVER (1 cycle): RAM_A and D_OUT held. Next edge: D_OE=0, go to IDLE. Data hold after WE rising edge = 1 cycle.
- Latency: request sampled at edge n gives ACK high after edge n+1+ACCESS_CYCLES; strobe low for exactly ACCESS_CYCLES cycles; earliest next grant at edge n+3+ACCESS_CYCLES.
- Requester rule: drop REQ (or present a new request) no later than the second edge after the ACK rises. A requester holding REQ high gets a repeated access.
- Arbitration (default, macro absent): fixed CP priority; on a simultaneous request, CP wins.
- The loser keeps REQ high and is served next, since the winner's REQ is low by then.
- Requests arriving in SETUP/ACCESS/RECOVER are only sampled in IDLE; no preemption.
- Never: RAM_OE_n and RAM_WE_n low together; D_OE=1 while RAM_OE_n=0.

Optional Feature:
ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, the requester that was not the last grantee wins, based on GNT_PI. GNT_PI resets to 1, so CP wins the first tie.
- Undefined: fixed CP priority as above.
- Single-requester behaviour and timing are identical in both builds.

Test Plan:
- CP write, ACCESS_CYCLES=3: CP_REQ=1, CP_WE=1, CP_ADDR=0x1122, CP_WDATA=0xAA sampled at edge 0 -> RAM_A=0x1122 and D_OUT=0xAA from edge 0; RAM_WE_n low edges 1..4; CP_ACK high edge 4..5; D_OE low after edge 5; SRAM[0x1122]=0xAA.
- CP read-back of 0x1122 -> RAM_OE_n low 3 cycles, D_OE=0 throughout, CP_RDATA=0xAA with CP_ACK; PI_ACK stays 0.
- Simultaneous CP write 0x0001←0x11 and PI read 0x0001: CP served first, then PI_RDATA=0x11. With ARB_ROUND_ROBIN_EN and a second tie, PI wins the second round.
- Back-to-back PI writes 0x1234←0x78 then 0x1235←0x79, REQ dropped/reasserted per rule -> two grants spaced ACCESS_CYCLES+3 cycles apart; both bytes stored.
- RESET_n pulsed low during ACCESS of a CP write -> strobes high and D_OE=0 immediately; no CP_ACK; BUSY=0; next request is processed normally.
- Invariant checker for the whole run: never RAM_OE_n=RAM_WE_n=0; never D_OE=1 with RAM_OE_n=0; ACK always exactly 1 cycle wide.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the two requester handshakes and the SRAM/shared-data-bus
//   signals of the SRAM arbiter.
//   slave  : arbiter side (requests and D_IN in; ACKs, RDATA, SRAM strobes,
//            D_OUT/D_OE, BUSY, GNT_PI out)
//   master : environment side (requesters, SRAM and bus), directions mirrored
interface sram_arbiter_if #(
    parameter int ADDR_W = 16
);
    // Clock-port (Amiga) requester
    logic              CP_REQ;
    logic              CP_WE;
    logic [ADDR_W-1:0] CP_ADDR;
    logic [7:0]        CP_WDATA;
    logic              CP_ACK;
    logic [7:0]        CP_RDATA;
    // Raspberry Pi requester
    logic              PI_REQ_M;
    logic              PI_WE_M;
    logic [ADDR_W-1:0] PI_ADDR;
    logic [7:0]        PI_WDATA;
    logic              PI_ACK;
    logic [7:0]        PI_RDATA;
    // SRAM and shared data bus
    logic [ADDR_W-1:0] RAM_A;
    logic              RAM_OE_n;
    logic              RAM_WE_n;
    logic [7:0]        D_OUT;
    logic              D_OE;
    logic [7:0]        D_IN;
    // Status
    logic              BUSY;
    logic              GNT_PI;

    modport slave (
        input  CP_REQ, CP_WE, CP_ADDR, CP_WDATA,
        input  PI_REQ_M, PI_WE_M, PI_ADDR, PI_WDATA,
        input  D_IN,
        output CP_ACK, CP_RDATA, PI_ACK, PI_RDATA,
        output RAM_A, RAM_OE_n, RAM_WE_n, D_OUT, D_OE,
        output BUSY, GNT_PI
    );

    modport master (
        output CP_REQ, CP_WE, CP_ADDR, CP_WDATA,
        output PI_REQ_M, PI_WE_M, PI_ADDR, PI_WDATA,
        output D_IN,
        input  CP_ACK, CP_RDATA, PI_ACK, PI_RDATA,
        input  RAM_A, RAM_OE_n, RAM_WE_n, D_OUT, D_OE,
        input  BUSY, GNT_PI
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Sequences every access to the shared 64Kx8 SRAM and arbitrates it between
//   the clock-port (CP) and Raspberry Pi (PI) register front ends. Each access
//   runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES strobe cycles) -> RECOVER.
//   All outputs are registered.
//
//   Ports:
//     CLK      system clock
//     RESET_n  asynchronous active-low reset; aborts any access in flight
//     bus      sram_arbiter_if.slave: CP/PI req/we/addr/wdata in, ack/rdata out;
//              RAM_A, RAM_OE_n, RAM_WE_n, D_OUT, D_OE out; D_IN in;
//              BUSY, GNT_PI out
//
//   Build option:
//     ARB_ROUND_ROBIN_EN  defined   -> ties go to the requester that was not
//                                      the last grantee (GNT_PI)
//                         undefined -> ties always go to CP
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 3,
    parameter int ADDR_W        = 16
) (
    input  logic          CLK,
    input  logic          RESET_n,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [7:0]        dout_q, dout_d;
    logic              doe_q, doe_d;
    logic              cp_ack_q, cp_ack_d;
    logic              pi_ack_q, pi_ack_d;
    logic [7:0]        cp_rdata_q, cp_rdata_d;
    logic [7:0]        pi_rdata_q, pi_rdata_d;
    logic              gnt_pi_q, gnt_pi_d;
    logic              busy_q, busy_d;
    logic              pick_pi;

    // Winner selection; only used when leaving IDLE.
    always_comb begin
        pick_pi = 1'b0;
        if (bus.PI_REQ_M && !bus.CP_REQ) begin
            pick_pi = 1'b1;
        end else if (bus.PI_REQ_M && bus.CP_REQ) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Alternate on ties: the side that did not own the last access wins.
            pick_pi = !gnt_pi_q;
`else
            pick_pi = 1'b0;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        ram_a_d    = ram_a_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        dout_d     = dout_q;
        doe_d      = doe_q;
        cp_ack_d   = 1'b0;
        pi_ack_d   = 1'b0;
        cp_rdata_d = cp_rdata_q;
        pi_rdata_d = pi_rdata_q;
        gnt_pi_d   = gnt_pi_q;

        unique case (state_q)
            IDLE: begin
                if (bus.CP_REQ || bus.PI_REQ_M) begin
                    gnt_pi_d = pick_pi;
                    ram_a_d  = pick_pi ? bus.PI_ADDR  : bus.CP_ADDR;
                    dout_d   = pick_pi ? bus.PI_WDATA : bus.CP_WDATA;
                    we_d     = pick_pi ? bus.PI_WE_M  : bus.CP_WE;
                    doe_d    = pick_pi ? bus.PI_WE_M  : bus.CP_WE;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                // Address/data have had one full cycle to settle; strobe now.
                if (we_q) begin
                    we_n_d = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
                cnt_d   = CNT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    oe_n_d = 1'b1;
                    we_n_d = 1'b1;
                    if (gnt_pi_q) begin
                        pi_ack_d = 1'b1;
                    end else begin
                        cp_ack_d = 1'b1;
                    end
                    // D_IN is sampled while OE is still low at this edge.
                    if (!we_q) begin
                        if (gnt_pi_q) begin
                            pi_rdata_d = bus.D_IN;
                        end else begin
                            cp_rdata_d = bus.D_IN;
                        end
                    end
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: begin
                // One cycle of data hold after the WE rising edge.
                doe_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            ram_a_q    <= '0;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dout_q     <= 8'h00;
            doe_q      <= 1'b0;
            cp_ack_q   <= 1'b0;
            pi_ack_q   <= 1'b0;
            cp_rdata_q <= 8'h00;
            pi_rdata_q <= 8'h00;
            gnt_pi_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            ram_a_q    <= ram_a_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
            cp_ack_q   <= cp_ack_d;
            pi_ack_q   <= pi_ack_d;
            cp_rdata_q <= cp_rdata_d;
            pi_rdata_q <= pi_rdata_d;
            gnt_pi_q   <= gnt_pi_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.RAM_A    = ram_a_q;
    assign bus.RAM_OE_n = oe_n_q;
    assign bus.RAM_WE_n = we_n_q;
    assign bus.D_OUT    = dout_q;
    assign bus.D_OE     = doe_q;
    assign bus.CP_ACK   = cp_ack_q;
    assign bus.PI_ACK   = pi_ack_q;
    assign bus.CP_RDATA = cp_rdata_q;
    assign bus.PI_RDATA = pi_rdata_q;
    assign bus.GNT_PI   = gnt_pi_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter: reset values, CP write/read timing,
//   simultaneous requests, back-to-back PI writes, reset abort, plus
//   continuous strobe/ACK invariants. Includes a 64Kx8 SRAM model.
module tb_sram_arbiter;

    localparam int AC = 3;

    logic CLK = 1'b0;
    logic RESET_n;

    always #5 CLK = ~CLK;

    sram_arbiter_if #(.ADDR_W(16)) bus ();

    sram_arbiter #(
        .ACCESS_CYCLES(AC),
        .ADDR_W       (16)
    ) dut (
        .CLK    (CLK),
        .RESET_n(RESET_n),
        .bus    (bus)
    );

    logic [7:0] mem [0:65535];
    int         errors = 0;
    int         checks = 0;
    logic       last_pi;

    // SRAM model: reads are combinational under OE, writes take D_OUT while WE is low.
    assign bus.D_IN = (!bus.RAM_OE_n) ? mem[bus.RAM_A] : 8'h00;

    always @(posedge CLK) begin
        if (bus.RAM_WE_n === 1'b0 && bus.D_OE === 1'b1) begin
            mem[bus.RAM_A] <= bus.D_OUT;
        end
    end

    // Whole-run invariants.
    logic cp_ack_prev = 1'b0;
    logic pi_ack_prev = 1'b0;

    always @(negedge CLK) begin
        if (RESET_n === 1'b1) begin
            checks++;
            if (bus.RAM_OE_n === 1'b0 && bus.RAM_WE_n === 1'b0) begin
                errors++;
                $display("FAIL inv_strobes: OE_n=%b WE_n=%b, both low", bus.RAM_OE_n, bus.RAM_WE_n);
            end
            if (bus.D_OE === 1'b1 && bus.RAM_OE_n === 1'b0) begin
                errors++;
                $display("FAIL inv_doe: D_OE=1 while OE_n=0");
            end
            if (cp_ack_prev && bus.CP_ACK === 1'b1) begin
                errors++;
                $display("FAIL inv_cp_ack_width: CP_ACK high two cycles, expected one");
            end
            if (pi_ack_prev && bus.PI_ACK === 1'b1) begin
                errors++;
                $display("FAIL inv_pi_ack_width: PI_ACK high two cycles, expected one");
            end
        end
        cp_ack_prev = (bus.CP_ACK === 1'b1);
        pi_ack_prev = (bus.PI_ACK === 1'b1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps until the selected ACK is seen (bounded); n=-1 on timeout.
    task automatic wait_ack(input bit pi, output int n, output int oe_low,
                            output bit doe_seen, output bit other_ack);
        n = -1; oe_low = 0; doe_seen = 1'b0; other_ack = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.RAM_OE_n === 1'b0) oe_low++;
            if (bus.D_OE === 1'b1) doe_seen = 1'b1;
            if ((pi ? bus.CP_ACK : bus.PI_ACK) === 1'b1) other_ack = 1'b1;
            if ((pi ? bus.PI_ACK : bus.CP_ACK) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET_n      = 1'b0;
        bus.CP_REQ   = 1'b0; bus.CP_WE   = 1'b0; bus.CP_ADDR = '0; bus.CP_WDATA = '0;
        bus.PI_REQ_M = 1'b0; bus.PI_WE_M = 1'b0; bus.PI_ADDR = '0; bus.PI_WDATA = '0;
        repeat (3) step();
        checks++;
        if ({bus.RAM_OE_n, bus.RAM_WE_n, bus.D_OE, bus.CP_ACK, bus.PI_ACK, bus.BUSY, bus.GNT_PI} !== 7'b1100001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1100001",
                     {bus.RAM_OE_n, bus.RAM_WE_n, bus.D_OE, bus.CP_ACK, bus.PI_ACK, bus.BUSY, bus.GNT_PI});
        end
        checks++;
        if (bus.RAM_A !== 16'h0000 || bus.D_OUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr_data: RAM_A=%h D_OUT=%h expected 0000/00", bus.RAM_A, bus.D_OUT);
        end
        checks++;
        if (bus.CP_RDATA !== 8'h00 || bus.PI_RDATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: CP_RDATA=%h PI_RDATA=%h expected 00/00", bus.CP_RDATA, bus.PI_RDATA);
        end
        RESET_n = 1'b1;
        step();
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: BUSY=%b expected 0", bus.BUSY);
        end
    endtask

    // First tie after reset: CP wins in both builds.
    task automatic test_tie_first();
        int n, oe; bit doe, oth;
        bus.CP_WE = 1'b1; bus.CP_ADDR = 16'h0001; bus.CP_WDATA = 8'h11; bus.CP_REQ = 1'b1;
        bus.PI_WE_M = 1'b0; bus.PI_ADDR = 16'h0001; bus.PI_REQ_M = 1'b1;
        wait_ack(1'b0, n, oe, doe, oth);
        bus.CP_REQ = 1'b0;
        checks++;
        if (n != AC + 2 || oth) begin
            errors++;
            $display("FAIL tie1_cp_first: cp ack at %0d pi_ack_seen=%b, expected %0d and 0", n, oth, AC + 2);
        end
        wait_ack(1'b1, n, oe, doe, oth);
        bus.PI_REQ_M = 1'b0;
        checks++;
        if (n != AC + 3) begin
            errors++;
            $display("FAIL tie1_pi_second: pi ack after %0d cycles, expected %0d", n, AC + 3);
        end
        checks++;
        if (bus.PI_RDATA !== 8'h11) begin
            errors++;
            $display("FAIL tie1_pi_rdata: got %h expected 11", bus.PI_RDATA);
        end
        checks++;
        if (oe != AC || doe) begin
            errors++;
            $display("FAIL tie1_pi_read_strobe: oe_low=%0d doe=%b expected %0d/0", oe, doe, AC);
        end
        last_pi = 1'b1;
        step();
    endtask

    // CP write, edge-exact.
    task automatic test_cp_write();
        int wlow = 0;
        bus.CP_WE = 1'b1; bus.CP_ADDR = 16'h1122; bus.CP_WDATA = 8'hAA; bus.CP_REQ = 1'b1;
        step();
        checks++;
        if (bus.RAM_A !== 16'h1122 || bus.D_OUT !== 8'hAA) begin
            errors++;
            $display("FAIL wr_latch: RAM_A=%h D_OUT=%h expected 1122/AA", bus.RAM_A, bus.D_OUT);
        end
        checks++;
        if ({bus.D_OE, bus.BUSY, bus.GNT_PI, bus.RAM_WE_n, bus.RAM_OE_n} !== 5'b11011) begin
            errors++;
            $display("FAIL wr_setup: D_OE/BUSY/GNT_PI/WE_n/OE_n=%b expected 11011",
                     {bus.D_OE, bus.BUSY, bus.GNT_PI, bus.RAM_WE_n, bus.RAM_OE_n});
        end
        for (int e = 1; e <= 5; e++) begin
            step();
            if (bus.RAM_WE_n === 1'b0) wlow++;
            if (e == 1) begin
                checks++;
                if (bus.RAM_WE_n !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_we_low: WE_n=%b after edge 1, expected 0", bus.RAM_WE_n);
                end
            end
            if (e == 4) begin
                checks++;
                if ({bus.CP_ACK, bus.RAM_WE_n, bus.D_OE, bus.PI_ACK} !== 4'b1110) begin
                    errors++;
                    $display("FAIL wr_ack: CP_ACK/WE_n/D_OE/PI_ACK=%b expected 1110",
                             {bus.CP_ACK, bus.RAM_WE_n, bus.D_OE, bus.PI_ACK});
                end
                bus.CP_REQ = 1'b0;
            end
            if (e == 5) begin
                checks++;
                if ({bus.CP_ACK, bus.D_OE, bus.BUSY} !== 3'b000) begin
                    errors++;
                    $display("FAIL wr_recover: CP_ACK/D_OE/BUSY=%b expected 000",
                             {bus.CP_ACK, bus.D_OE, bus.BUSY});
                end
            end
        end
        checks++;
        if (wlow != AC) begin
            errors++;
            $display("FAIL wr_we_width: WE_n low %0d cycles, expected %0d", wlow, AC);
        end
        checks++;
        if (mem[16'h1122] !== 8'hAA) begin
            errors++;
            $display("FAIL wr_mem: SRAM[1122]=%h expected AA", mem[16'h1122]);
        end
        last_pi = 1'b0;
    endtask

    task automatic test_cp_read();
        int n, oe; bit doe, oth;
        step();
        bus.CP_WE = 1'b0; bus.CP_ADDR = 16'h1122; bus.CP_REQ = 1'b1;
        wait_ack(1'b0, n, oe, doe, oth);
        bus.CP_REQ = 1'b0;
        checks++;
        if (n != AC + 2) begin
            errors++;
            $display("FAIL rd_latency: ack after %0d cycles, expected %0d", n, AC + 2);
        end
        checks++;
        if (oe != AC || doe || oth) begin
            errors++;
            $display("FAIL rd_strobe: oe_low=%0d doe=%b pi_ack=%b expected %0d/0/0", oe, doe, oth, AC);
        end
        checks++;
        if (bus.CP_RDATA !== 8'hAA) begin
            errors++;
            $display("FAIL rd_data: CP_RDATA=%h expected AA", bus.CP_RDATA);
        end
        last_pi = 1'b0;
        step();
    endtask

    // Second tie, last grantee CP: round-robin hands it to PI, fixed priority to CP.
    task automatic test_tie_second();
        int n, oe; bit doe, oth;
        bit exp_pi;
`ifdef ARB_ROUND_ROBIN_EN
        exp_pi = !last_pi;
`else
        exp_pi = 1'b0;
`endif
        bus.CP_WE = 1'b1; bus.CP_ADDR = 16'h0100; bus.CP_WDATA = 8'h22; bus.CP_REQ = 1'b1;
        bus.PI_WE_M = 1'b1; bus.PI_ADDR = 16'h0200; bus.PI_WDATA = 8'h33; bus.PI_REQ_M = 1'b1;
        wait_ack(exp_pi, n, oe, doe, oth);
        if (exp_pi) bus.PI_REQ_M = 1'b0; else bus.CP_REQ = 1'b0;
        checks++;
        if (n != AC + 2 || oth) begin
            errors++;
            $display("FAIL tie2_winner: winner_pi=%b ack at %0d other_ack=%b, expected %0d and 0",
                     exp_pi, n, oth, AC + 2);
        end
        wait_ack(!exp_pi, n, oe, doe, oth);
        if (exp_pi) bus.CP_REQ = 1'b0; else bus.PI_REQ_M = 1'b0;
        checks++;
        if (n != AC + 3) begin
            errors++;
            $display("FAIL tie2_loser: ack after %0d cycles, expected %0d", n, AC + 3);
        end
        checks++;
        if (mem[16'h0100] !== 8'h22 || mem[16'h0200] !== 8'h33) begin
            errors++;
            $display("FAIL tie2_mem: SRAM[0100]=%h SRAM[0200]=%h expected 22/33",
                     mem[16'h0100], mem[16'h0200]);
        end
        last_pi = !exp_pi;
        step();
    endtask

    task automatic test_back_to_back();
        int n, oe; bit doe, oth;
        bus.PI_WE_M = 1'b1; bus.PI_ADDR = 16'h1234; bus.PI_WDATA = 8'h78; bus.PI_REQ_M = 1'b1;
        wait_ack(1'b1, n, oe, doe, oth);
        // Keep REQ high and present the next write right after the ACK.
        bus.PI_ADDR = 16'h1235; bus.PI_WDATA = 8'h79;
        checks++;
        if (n != AC + 2 || bus.GNT_PI !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: ack at %0d GNT_PI=%b, expected %0d/1", n, bus.GNT_PI, AC + 2);
        end
        wait_ack(1'b1, n, oe, doe, oth);
        bus.PI_REQ_M = 1'b0;
        checks++;
        if (n != AC + 3) begin
            errors++;
            $display("FAIL b2b_spacing: second ack %0d cycles later, expected %0d", n, AC + 3);
        end
        checks++;
        if (mem[16'h1234] !== 8'h78 || mem[16'h1235] !== 8'h79) begin
            errors++;
            $display("FAIL b2b_mem: SRAM[1234]=%h SRAM[1235]=%h expected 78/79",
                     mem[16'h1234], mem[16'h1235]);
        end
        last_pi = 1'b1;
        step();
    endtask

    task automatic test_reset_abort();
        int n, oe; bit doe, oth;
        bit ack_seen = 1'b0;
        bus.CP_WE = 1'b1; bus.CP_ADDR = 16'h2000; bus.CP_WDATA = 8'h55; bus.CP_REQ = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.RAM_WE_n !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_access: WE_n=%b expected 0 before reset", bus.RAM_WE_n);
        end
        RESET_n = 1'b0;
        #1;
        checks++;
        if ({bus.RAM_OE_n, bus.RAM_WE_n, bus.D_OE, bus.BUSY, bus.CP_ACK, bus.GNT_PI} !== 6'b110001) begin
            errors++;
            $display("FAIL abort_release: OE_n/WE_n/D_OE/BUSY/CP_ACK/GNT_PI=%b expected 110001",
                     {bus.RAM_OE_n, bus.RAM_WE_n, bus.D_OE, bus.BUSY, bus.CP_ACK, bus.GNT_PI});
        end
        bus.CP_REQ = 1'b0;
        step();
        RESET_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.CP_ACK === 1'b1) ack_seen = 1'b1;
        end
        checks++;
        if (ack_seen) begin
            errors++;
            $display("FAIL abort_no_ack: CP_ACK=1 seen after aborted access, expected none");
        end
        bus.PI_WE_M = 1'b0; bus.PI_ADDR = 16'h1235; bus.PI_REQ_M = 1'b1;
        wait_ack(1'b1, n, oe, doe, oth);
        bus.PI_REQ_M = 1'b0;
        checks++;
        if (n != AC + 2 || bus.PI_RDATA !== 8'h79) begin
            errors++;
            $display("FAIL abort_recover: ack at %0d PI_RDATA=%h, expected %0d/79", n, bus.PI_RDATA, AC + 2);
        end
        checks++;
        if (bus.CP_RDATA !== 8'h00) begin
            errors++;
            $display("FAIL abort_cp_rdata: CP_RDATA=%h expected 00 after reset", bus.CP_RDATA);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        last_pi = 1'b1;
        test_reset();
        test_tie_first();
        test_cp_write();
        test_cp_read();
        test_tie_second();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
